lisa_rx_fifo: RTL and testbench
===============================

LISA_RX_FIFO -- requirements
Module: lisa_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; SHALL be a power of 2, from 2 to 16.
REQ-002 Parameter: AW, default 2, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: rx_d  input  8  byte presented by the upstream 8N1 receiver.
REQ-006 Port: rx_avail  input  1  upstream byte valid; level signal.
REQ-007 Port: rx_rd  output  1  read acknowledge to upstream; the upstream acts on its rising edge.
REQ-008 Port: pop  input  1  consumer removes the head entry; sampled every cycle.
REQ-009 Port: dout  output  8  head entry, show-ahead.
REQ-010 Port: empty  output  1  high when level==0.
REQ-011 Port: full  output  1  high when level==DEPTH.
REQ-012 Port: level  output  AW+1  number of stored entries.
REQ-013 Port: ovr  output  1  sticky backpressure flag.
REQ-014 Port: ovr_clr  input  1  clears ovr.

Function
REQ-015 Storage SHALL be a DEPTH x 8 array with wr_ptr and rd_ptr (AW bits each) that wrap modulo DEPTH, plus a level counter (AW+1 bits).
REQ-016 Drain FSM SHALL have three states: IDLE, ACK and WAIT.
REQ-017 IDLE: if rx_avail=1 and full=0 (registered value), the block SHALL write rx_d at wr_ptr, increment wr_ptr, and go to ACK; otherwise it SHALL stay in IDLE.
REQ-018 ACK: rx_rd=1 for exactly this one cycle; the FSM SHALL then go to WAIT unconditionally.
REQ-019 WAIT: rx_rd=0; the FSM SHALL go to IDLE when rx_avail=0 and otherwise stay in WAIT.
REQ-020 rx_rd SHALL be a registered output, high only in ACK; each upstream byte SHALL be written exactly once.
REQ-021 Push-to-visibility latency: a byte written in IDLE SHALL appear on dout/empty/level on the next cycle.
REQ-022 Pop: if pop=1 and empty=0, rd_ptr SHALL increment and level SHALL decrement; pop while empty SHALL be ignored with no state change.
REQ-023 Push and pop in the same cycle SHALL leave level unchanged and advance both pointers.
REQ-024 When full=1, simultaneous pop and rx_avail SHALL NOT push that cycle; the push SHALL occur on a later IDLE cycle.
REQ-025 dout SHALL equal mem[rd_ptr], and its value is undefined-but-stable while empty.
REQ-026 ovr SHALL set in any IDLE cycle where rx_avail=1 and full=1.
REQ-027 ovr_clr=1 SHALL clear ovr; if set and clear coincide, set SHALL win.
REQ-028 level SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-029 With rst_n=0 at a clock edge: FSM=IDLE, wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, rx_rd=0, ovr=0.
REQ-030 Memory contents SHALL NOT be reset; dout after reset is don't-care.
REQ-031 Reset asserted mid-handshake (in ACK or WAIT) SHALL abort the handshake and drive rx_rd=0 on the next cycle; the FSM SHALL then restart in IDLE.

Verification
REQ-032 Single byte: rx_avail=1, rx_d=0x5A, with rx_avail dropped 1 cycle after rx_rd -> rx_rd pulses 1 cycle, then empty=0, level=1, dout=0x5A; pop -> empty=1.
REQ-033 Fill: 4 bytes 0x01..0x04 at DEPTH=4, no pops -> full=1, level=4; a 5th rx_avail -> no rx_rd, ovr=1; then 4 pops -> dout sequence 0x01,0x02,0x03,0x04, and the 5th byte is then accepted.
REQ-034 Simultaneous: level=2, pop coincides with a push -> level stays 2, order preserved.
REQ-035 Pop when empty -> level stays 0 and pointers unchanged.
REQ-036 Wrap: 10 push/pop pairs at DEPTH=4 -> data order correct across pointer wrap, and level returns to 0.
REQ-037 Reset in WAIT -> rx_rd=0, level=0, FSM in IDLE; an rx_avail still held high after reset -> captured once.

Source files
------------

// File: rtl/lisa_rx_fifo.sv
// Receive FIFO fed by an 8N1 receiver through a level/acknowledge handshake.
// Latency: a byte captured in IDLE shows on dout/empty/level on the next cycle.
// Backpressure: no acknowledge while full; an offered byte then sets sticky ovr.
module lisa_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_d,
  input  logic          rx_avail,
  output logic          rx_rd,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovr,
  input  logic          ovr_clr
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q,  level_d;
  logic            rx_rd_q;
  logic            ovr_q,    ovr_d;

  logic            push;
  logic            pop_ok;
  logic            ovr_set;

  // Full/empty come straight from the registered level, so the drain FSM
  // only ever looks at last cycle's occupancy.
  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_L);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign rx_rd   = rx_rd_q;
  assign ovr     = ovr_q;

  // A push is only taken in IDLE; a pop on a full FIFO never frees room for
  // the same cycle, the offered byte waits for the next IDLE cycle.
  assign push    = (state_q == IDLE) && rx_avail && !full;
  assign pop_ok  = pop && !empty;
  assign ovr_set = (state_q == IDLE) && rx_avail && full;

  // Next-state for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovr_d    = ovr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    // Set has priority over clear so an overrun is never lost.
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // Pointer, level and overrun registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= rx_d;
    end
  end

  // Drain handshake: capture in IDLE, acknowledge for one cycle in ACK, then
  // hold in WAIT until the receiver drops rx_avail so each byte is taken once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rx_rd_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            state_q <= ACK;
            rx_rd_q <= 1'b1;
          end else begin
            rx_rd_q <= 1'b0;
          end
        end
        ACK: begin
          state_q <= WAIT;
          rx_rd_q <= 1'b0;
        end
        WAIT: begin
          rx_rd_q <= 1'b0;
          if (!rx_avail) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rx_rd_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lisa_rx_fifo.sv
// Directed bench for lisa_rx_fifo at DEPTH=4.
// Inputs change 1ns after the rising edge; outputs are checked there too.
// Expected values are hand-computed per vector.
module tb_lisa_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_d;
  logic       rx_avail;
  logic       rx_rd;
  logic       pop;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [2:0] level;
  logic       ovr;
  logic       ovr_clr;

  int n_chk  = 0;
  int n_pass = 0;

  lisa_rx_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_d     (rx_d),
    .rx_avail (rx_avail),
    .rx_rd    (rx_rd),
    .pop      (pop),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .ovr      (ovr),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake from IDLE: offer, see the one-cycle ack, drop, return to IDLE.
  task automatic push_byte(input logic [7:0] b);
    rx_d     = b;
    rx_avail = 1'b1;
    tick();
    chk("push_ack", {31'd0, rx_rd}, 32'd1);
    rx_avail = 1'b0;
    tick();
    chk("push_ack_drop", {31'd0, rx_rd}, 32'd0);
    tick();
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_d     = 8'h00;
    rx_avail = 1'b0;
    pop      = 1'b0;
    ovr_clr  = 1'b0;
    tick();
    tick();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_rx_rd", {31'd0, rx_rd}, 32'd0);
    chk("rst_ovr",   {31'd0, ovr},   32'd0);
    rst_n = 1'b1;
    tick();

    // Single byte: data visible the cycle after capture, alongside the ack.
    rx_d     = 8'h5A;
    rx_avail = 1'b1;
    tick();
    chk("single_rx_rd", {31'd0, rx_rd}, 32'd1);
    chk("single_empty", {31'd0, empty}, 32'd0);
    chk("single_level", {29'd0, level}, 32'd1);
    chk("single_dout",  {24'd0, dout},  32'h5A);
    rx_avail = 1'b0;
    tick();
    chk("single_rx_rd_low", {31'd0, rx_rd}, 32'd0);
    tick();
    pop_one();
    chk("single_pop_empty", {31'd0, empty}, 32'd1);

    // Fill to DEPTH, then overrun.
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
    end
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_level", {29'd0, level}, 32'd4);
    rx_d     = 8'h05;
    rx_avail = 1'b1;
    tick();
    chk("ovr_no_ack", {31'd0, rx_rd}, 32'd0);
    chk("ovr_set",    {31'd0, ovr},   32'd1);
    chk("ovr_level",  {29'd0, level}, 32'd4);
    ovr_clr = 1'b1;
    tick();
    chk("ovr_set_wins", {31'd0, ovr}, 32'd1);
    ovr_clr = 1'b0;
    chk("drain_d0", {24'd0, dout}, 32'h01);
    pop = 1'b1;
    tick();
    chk("drain_d1",     {24'd0, dout},  32'h02);
    chk("drain_l1",     {29'd0, level}, 32'd3);
    chk("drain_noack",  {31'd0, rx_rd}, 32'd0);
    tick();
    chk("drain_d2",     {24'd0, dout},  32'h03);
    chk("drain_l2",     {29'd0, level}, 32'd3);
    chk("drain_5th_ack", {31'd0, rx_rd}, 32'd1);
    tick();
    chk("drain_d3", {24'd0, dout},  32'h04);
    chk("drain_l3", {29'd0, level}, 32'd2);
    tick();
    chk("drain_d4", {24'd0, dout},  32'h05);
    chk("drain_l4", {29'd0, level}, 32'd1);
    pop      = 1'b0;
    rx_avail = 1'b0;
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_cleared", {31'd0, ovr}, 32'd0);
    pop_one();
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Simultaneous push and pop at level 2.
    push_byte(8'hAA);
    push_byte(8'hBB);
    rx_d     = 8'hCC;
    rx_avail = 1'b1;
    pop      = 1'b1;
    tick();
    chk("simul_level", {29'd0, level}, 32'd2);
    chk("simul_dout",  {24'd0, dout},  32'hBB);
    chk("simul_ack",   {31'd0, rx_rd}, 32'd1);
    pop      = 1'b0;
    rx_avail = 1'b0;
    tick();
    tick();
    pop_one();
    chk("simul_order", {24'd0, dout}, 32'hCC);
    pop_one();
    chk("simul_empty", {31'd0, empty}, 32'd1);

    // Pop while empty is ignored; a later byte lands at the head.
    pop = 1'b1;
    tick();
    tick();
    pop = 1'b0;
    chk("popempty_level", {29'd0, level}, 32'd0);
    chk("popempty_empty", {31'd0, empty}, 32'd1);
    push_byte(8'hDD);
    chk("popempty_dout",  {24'd0, dout},  32'hDD);
    chk("popempty_level1", {29'd0, level}, 32'd1);
    pop_one();

    // Ten push/pop pairs across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h10 + 8'(i));
      chk("wrap_dout", {24'd0, dout}, 32'h10 + 32'(i));
      pop_one();
    end
    chk("wrap_level", {29'd0, level}, 32'd0);

    // Reset in WAIT with rx_avail still high.
    rx_d     = 8'h77;
    rx_avail = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstwait_rx_rd", {31'd0, rx_rd}, 32'd0);
    chk("rstwait_level", {29'd0, level}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rstwait_recap_ack", {31'd0, rx_rd}, 32'd1);
    tick();
    tick();
    chk("rstwait_once", {29'd0, level}, 32'd1);
    rx_avail = 1'b0;
    tick();
    tick();
    chk("rstwait_level_final", {29'd0, level}, 32'd1);
    chk("rstwait_dout",        {24'd0, dout},  32'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
